// File: rtl/id_token_collector.sv
// id_token_collector: delimits identifier runs on the char stream and queues {len, first, last} tokens
module id_token_collector #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       char,
  input  logic             match,
  input  logic             tok_ready,
  output logic             tok_valid,
  output logic [LEN_W-1:0] tok_len,
  output logic [7:0]       tok_first,
  output logic [7:0]       tok_last,
  output logic [CNT_W-1:0] tok_count,
  output logic [CNT_W-1:0] drop_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [7:0] char_d, first, last;
  logic [LEN_W-1:0] len;
  logic last_match, alpha, digit, push_req, pop, full, push, drop;
  logic [LEN_W-1:0] mem_len [DEPTH];
  logic [7:0] mem_first [DEPTH];
  logic [7:0] mem_last [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] occ;
  always_comb begin
    alpha = (char_d >= 8'h41 && char_d <= 8'h5a) || (char_d >= 8'h61 && char_d <= 8'h7a);
    digit = char_d >= 8'h30 && char_d <= 8'h39;
    state_nx = (state == IDLE) ? (alpha ? RUN : IDLE) : ((alpha || digit) ? RUN : IDLE);
    push_req = (state == RUN) && !(alpha || digit) && last_match;
    pop = tok_valid && tok_ready;
    full = occ == (AW+1)'(DEPTH);
    push = push_req && (!full || pop);
    drop = push_req && full && !pop;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_d <= '0;
      len <= '0;
      first <= '0;
      last <= '0;
      last_match <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
      tok_count <= '0;
      drop_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_len[i] <= '0;
        mem_first[i] <= '0;
        mem_last[i] <= '0;
      end
    end else begin
      char_d <= char;
      if (state == IDLE && alpha) begin
        len <= LEN_W'(1);
        first <= char_d;
        last <= char_d;
        last_match <= match;
      end else if (state == RUN && (alpha || digit)) begin
        len <= (&len) ? len : len + 1'b1;
        last <= char_d;
        last_match <= match;
      end
      if (push) begin
        mem_len[wr_ptr] <= len;
        mem_first[wr_ptr] <= first;
        mem_last[wr_ptr] <= last;
        wr_ptr <= wr_ptr + 1'b1;
        tok_count <= tok_count + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
      if (drop && !(&drop_count)) drop_count <= drop_count + 1'b1;
    end
  end
  assign tok_valid = occ != '0;
  assign tok_len = mem_len[rd_ptr];
  assign tok_first = mem_first[rd_ptr];
  assign tok_last = mem_last[rd_ptr];
endmodule

// File: tb/tb_id_token_collector.sv
// tb_id_token_collector: vector table, corner sequences and random stream against a queue-based model
module tb_id_token_collector;
  logic clk = 0, rst_n = 0, match = 0, tok_ready = 0;
  logic [7:0] char = 0;
  logic tok_valid;
  logic [7:0] tok_len, tok_first, tok_last;
  logic [15:0] tok_count, drop_count;
  int total = 0, bad = 0;
  id_token_collector dut (.clk(clk), .rst_n(rst_n), .char(char), .match(match), .tok_ready(tok_ready),
    .tok_valid(tok_valid), .tok_len(tok_len), .tok_first(tok_first), .tok_last(tok_last),
    .tok_count(tok_count), .drop_count(drop_count));
  always #5 clk = ~clk;
  typedef struct {logic [7:0] len, first, last;} tok_t;
  tok_t q[$];
  logic [7:0] m_cd, m_first, m_last;
  int m_len, m_cnt, m_drop;
  bit m_run, m_lm, rec_in, pend, rnd_match;
  typedef struct {string s; int cnt, drop; bit valid; int len; logic [7:0] first, last;} vec_t;
  vec_t vt[6];
  function automatic bit isal(logic [7:0] c);
    return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
  endfunction
  function automatic bit isdg(logic [7:0] c);
    return c >= "0" && c <= "9";
  endfunction
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_cd = 0; m_first = 0; m_last = 0; m_len = 0; m_cnt = 0; m_drop = 0;
    m_run = 0; m_lm = 0; rec_in = 0; pend = 0;
  endtask
  task automatic check_all();
    chk("valid", tok_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("len", tok_len, q[0].len);
      chk("first", tok_first, q[0].first);
      chk("last", tok_last, q[0].last);
    end
    chk("count", tok_count, m_cnt);
    chk("drops", drop_count, m_drop);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; char = 0; match = 0; tok_ready = 0;
    model_reset();
    #2;
    chk("rst_valid", tok_valid, 0);
    chk("rst_len", tok_len, 0);
    chk("rst_first", tok_first, 0);
    chk("rst_last", tok_last, 0);
    chk("rst_count", tok_count, 0);
    chk("rst_drops", drop_count, 0);
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic cyc(input logic [7:0] c, input logic r);
    bit pop, preq, mt;
    mt = rnd_match ? 1'($urandom) : pend;
    char = c; match = mt; tok_ready = r;
    if (isal(c)) begin rec_in = 1; pend = 0; end
    else if (isdg(c)) pend = rec_in;
    else begin rec_in = 0; pend = 0; end
    @(posedge clk);
    pop = q.size() != 0 && r;
    preq = 0;
    if (!m_run) begin
      if (isal(m_cd)) begin m_run = 1; m_len = 1; m_first = m_cd; m_last = m_cd; m_lm = mt; end
    end else if (isal(m_cd) || isdg(m_cd)) begin
      m_len = (m_len < 255) ? m_len + 1 : 255; m_last = m_cd; m_lm = mt;
    end else begin
      m_run = 0; preq = m_lm;
    end
    if (pop) void'(q.pop_front());
    if (preq) begin
      if (q.size() < 4) begin q.push_back('{8'(m_len), m_first, m_last}); m_cnt = (m_cnt + 1) % 65536; end
      else if (m_drop < 65535) m_drop++;
    end
    m_cd = c;
    #1;
    check_all();
  endtask
  task automatic send(string s, logic r);
    for (int i = 0; i < s.len(); i++) cyc(s[i], r);
  endtask
  initial begin
    vt[0] = '{"ab12 ", 1, 0, 1, 4, "a", "2"};
    vt[1] = '{"ab a1b ", 0, 0, 0, 0, 0, 0};
    vt[2] = '{"9x7;", 1, 0, 1, 2, "x", "7"};
    vt[3] = '{"a1 a1 a1 a1 a1 ", 4, 1, 1, 2, "a", "1"};
    vt[4] = '{"ab12cd x9 ", 1, 0, 1, 2, "x", "9"};
    vt[5] = '{"Zz0Q9 ", 1, 0, 1, 5, "Z", "9"};
    rnd_match = 0;
    for (int v = 0; v < 6; v++) begin
      do_reset();
      send(vt[v].s, 0);
      send("  ", 0);
      chk("tbl_count", tok_count, vt[v].cnt);
      chk("tbl_drops", drop_count, vt[v].drop);
      chk("tbl_valid", tok_valid, vt[v].valid);
      if (vt[v].valid) begin
        chk("tbl_len", tok_len, vt[v].len);
        chk("tbl_first", tok_first, vt[v].first);
        chk("tbl_last", tok_last, vt[v].last);
      end
    end
    do_reset();
    send("ab12", 1);
    cyc(" ", 1);
    chk("lat_k1", tok_valid, 0);
    cyc(" ", 1);
    chk("lat_k2", tok_valid, 1);
    chk("lat_len", tok_len, 4);
    chk("lat_first", tok_first, "a");
    cyc(" ", 1);
    chk("lat_popped", tok_valid, 0);
    chk("lat_count", tok_count, 1);
    do_reset();
    send("a1 b2 c3 d4 e5 ", 0);
    send("  ", 0);
    chk("full_drops", drop_count, 1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_first", tok_first, "a" + i);
      chk("drain_len", tok_len, 2);
      cyc(" ", 1);
    end
    chk("drained", tok_valid, 0);
    do_reset();
    cyc("a", 0);
    for (int i = 0; i < 300; i++) cyc("5", 0);
    send("   ", 0);
    chk("sat_len", tok_len, 255);
    chk("sat_first", tok_first, "a");
    chk("sat_last", tok_last, "5");
    do_reset();
    send("abc1", 1);
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("mid_valid", tok_valid, 0);
    chk("mid_count", tok_count, 0);
    chk("mid_len", tok_len, 0);
    @(negedge clk) rst_n = 1;
    send("   ", 1);
    chk("mid_nopush", tok_count, 0);
    do_reset();
    send("a1 a1 a1 a1 a1", 0);
    cyc(" ", 0);
    cyc(" ", 1);
    chk("pp_drops", drop_count, 0);
    chk("pp_count", tok_count, 5);
    send("     ", 1);
    chk("pp_empty", tok_valid, 0);
    do_reset();
    rnd_match = 1;
    for (int i = 0; i < 3000; i++) begin
      int k;
      logic [7:0] c;
      k = $urandom_range(0, 3);
      c = k == 0 ? 8'($urandom_range(97, 122)) : k == 1 ? 8'($urandom_range(65, 90)) :
          k == 2 ? 8'($urandom_range(48, 57)) : 8'($urandom_range(32, 47));
      cyc(c, i < 1500 ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
